serial_normalizer: RTL and testbench



---
 rtl/serial_normalizer_if.sv | 23 ++
 rtl/serial_normalizer.sv | 90 +++++++++
 tb/tb_serial_normalizer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/serial_normalizer_if.sv
// Start/busy/done handshake bundle between controller and normalizer.
interface serial_normalizer_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [SHW-1:0]   shamt;
  logic             zero;

  modport master (
    output start, in,
    input  busy, done, out, shamt, zero
  );

  modport slave (
    input  start, in,
    output busy, done, out, shamt, zero
  );
endinterface

// File: rtl/serial_normalizer.sv
// Multi-cycle left normalizer: shifts one bit per clock until MSB is set,
// reporting the normalized value and the leading-zero count.
module serial_normalizer #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic               clk,
  input logic               rst_n,
  serial_normalizer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [SHW-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic             zero_q, zero_d;
  logic             busy_q, done_q;

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
    out_d   = out_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          sreg_d  = bus.in;
          cnt_d   = '0;
          zero_d  = (bus.in == '0);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // An all-zero operand retires here with out=0, shamt=0.
        if (sreg[WIDTH-1] || (sreg == '0)) begin
          out_d   = sreg;
          shamt_d = cnt;
          state_d = DONE;
        end else begin
          sreg_d = sreg << 1;
          cnt_d  = cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      out_q   <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      sreg    <= sreg_d;
      cnt     <= cnt_d;
      out_q   <= out_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.shamt = shamt_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_serial_normalizer.sv
// Scoreboard bench for serial_normalizer: directed operands,
// monitor pops expected results on each done pulse.
module tb_serial_normalizer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   done_cnt;

  typedef struct {
    logic [7:0] o;
    logic [2:0] s;
    logic       z;
  } exp_t;

  exp_t sb[$];

  serial_normalizer_if #(.WIDTH(8), .SHW(3)) nif ();

  serial_normalizer #(.WIDTH(8), .SHW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (nif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && nif.done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got out=%0d with empty scoreboard",
                 nif.out);
      end else begin
        e = sb.pop_front();
        chk("out", int'(nif.out), int'(e.o));
        chk("shamt", int'(nif.shamt), int'(e.s));
        chk("zero", int'(nif.zero), int'(e.z));
        chk("msb_or_zero", int'(nif.out[7] | nif.zero), 1);
      end
    end
  end

  task automatic wait_done(output int edges, output int bcyc);
    edges = 0;
    bcyc  = 0;
    while (!nif.done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (nif.busy) bcyc++;
    end
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] eo,
                     input logic [2:0] es, input logic ez,
                     input int elat);
    int edges;
    int bcyc;
    int d0;
    sb.push_back('{o: eo, s: es, z: ez});
    d0 = done_cnt;
    @(negedge clk);
    nif.start = 1'b1;
    nif.in    = x;
    @(posedge clk);
    #1;
    nif.start = 1'b0;
    nif.in    = ~x;
    chk("busy_after_start", int'(nif.busy), 1);
    wait_done(edges, bcyc);
    chk("latency", edges, elat);
    chk("busy_cycles", bcyc + 1, elat + 1);
    @(posedge clk);
    #1;
    chk("idle_after", int'({nif.busy, nif.done}), 0);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    int bcyc;
    int d0;
    errors    = 0;
    checks    = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    nif.start = 1'b0;
    nif.in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(nif.busy), 0);
    chk("rst_done", int'(nif.done), 0);
    chk("rst_out", int'(nif.out), 0);
    chk("rst_shamt", int'(nif.shamt), 0);
    chk("rst_zero", int'(nif.zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(8'b00000110, 8'b11000000, 3'd5, 1'b0, 6);
    run(8'b10000000, 8'b10000000, 3'd0, 1'b0, 1);
    run(8'b00000001, 8'b10000000, 3'd7, 1'b0, 8);
    run(8'b00000000, 8'b00000000, 3'd0, 1'b1, 1);
    run(8'b01000000, 8'b10000000, 3'd1, 1'b0, 2);

    // second start during SHIFT must be ignored
    sb.push_back('{o: 8'b10000000, s: 3'd4, z: 1'b0});
    d0 = done_cnt;
    @(negedge clk);
    nif.start = 1'b1;
    nif.in    = 8'b00001000;
    @(posedge clk);
    #1;
    nif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nif.start = 1'b1;
    nif.in    = 8'b00000001;
    @(negedge clk);
    nif.start = 1'b0;
    edges = 2;
    bcyc  = 0;
    while (!nif.done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("ignored_start_latency", edges, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_start_pulses", done_cnt - d0, 1);
    chk("ignored_start_idle", int'(nif.busy), 0);

    // asynchronous reset mid-operation
    d0 = done_cnt;
    @(negedge clk);
    nif.start = 1'b1;
    nif.in    = 8'b00000001;
    @(posedge clk);
    #1;
    nif.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", int'(nif.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(nif.busy), 0);
    chk("arst_done", int'(nif.done), 0);
    chk("arst_out", int'(nif.out), 0);
    chk("arst_shamt", int'(nif.shamt), 0);
    chk("arst_zero", int'(nif.zero), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("arst_no_done", done_cnt - d0, 0);
    chk("arst_busy_later", int'(nif.busy), 0);

    run(8'b00100000, 8'b10000000, 3'd2, 1'b0, 3);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
